mem_lsu: RTL and testbench

- Memory-access stage sitting between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Turns load/store requests from EX/MEM into a req/ack transaction on the data-memory bus.
- Stalls the upstream pipeline while a transaction is outstanding.
- Aligns and sign/zero-extends load data, then presents result, load data and control to MEM/WB.
- Non-memory instructions pass through combinationally with no stall.

---
 rtl/mem_lsu_pkg.sv | 26 ++
 rtl/mem_lsu_if.sv | 20 ++
 rtl/mem_lsu_align.sv | 48 ++++
 rtl/mem_lsu.sv | 125 ++++++++++++
 tb/tb_mem_lsu.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the memory-access stage.
// Holds the access-size encodings, the LSU state encoding and the
// alignment rule used to decide whether a request may reach the bus.
package mem_lsu_pkg;

   localparam logic [1:0] SIZE_B = 2'd0;
   localparam logic [1:0] SIZE_H = 2'd1;
   localparam logic [1:0] SIZE_W = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Size code 3 has no legal meaning, so it is treated as misaligned.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] ofs);
      case (size)
         SIZE_B:  return 1'b0;
         SIZE_H:  return ofs[0];
         SIZE_W:  return (ofs != 2'd0);
         default: return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// Data-memory bus between the LSU and the data memory.
//   req   : request, held until ack or timeout
//   we    : write enable
//   addr  : word-aligned byte address
//   wdata : store data replicated across byte lanes
//   be    : byte enables
//   ack   : one-cycle completion pulse from memory
//   rdata : read data, valid with ack
interface mem_lsu_if;
   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [3:0]  be;
   logic        ack;
   logic [31:0] rdata;

   modport master (output req, we, addr, wdata, be, input ack, rdata);
   modport slave  (input req, we, addr, wdata, be, output ack, rdata);
endinterface

// File: rtl/mem_lsu_align.sv
// lsu_align: combinational lane logic for the LSU.
//   size, ofs : access size and byte offset within the word
//   sext      : sign-extend loaded data
//   wdata     : raw store data       -> wrep : store data replicated into lanes
//   rdata     : raw bus read data    -> rext : addressed lane, extended
//   be        : byte enables for the access
module lsu_align
   import mem_lsu_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  ofs,
   input  logic        sext,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wrep,
   output logic [31:0] rext
);

   logic [31:0] sh;

   // Move the addressed lane down to bit 0 before extension.
   assign sh = rdata >> {ofs, 3'b000};

   always_comb begin
      be   = 4'b1111;
      wrep = wdata;
      rext = sh;
      case (size)
         SIZE_B: begin
            be   = 4'b0001 << ofs;
            wrep = {4{wdata[7:0]}};
            rext = {{24{sext & sh[7]}}, sh[7:0]};
         end
         SIZE_H: begin
            be   = 4'b0011 << ofs;
            wrep = {2{wdata[15:0]}};
            rext = {{16{sext & sh[15]}}, sh[15:0]};
         end
         default: begin
            be   = 4'b1111;
            wrep = wdata;
            rext = sh;
         end
      endcase
   end

endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: memory-access stage between EX/MEM and MEM/WB.
// Converts loads/stores into a req/ack bus transaction, stalls upstream while
// it is outstanding, aligns/extends load data and forwards control to MEM/WB.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   mem_* inputs                  : instruction held in EX/MEM
//   dm (master)                   : data-memory bus
//   out_Alu_Result/mo/m2reg/wreg/rn : to MEM/WB
//   mem_stall                     : freeze upstream pipeline registers
//   mem_exc                       : misaligned access or bus timeout pulse
module mem_lsu
   import mem_lsu_pkg::*;
#(
   parameter int TIMEOUT = 16,
   parameter int CW      = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_valid,
   input  logic [31:0] mem_Alu_Result,
   input  logic [31:0] mem_wdata,
   input  logic        mem_m2reg,
   input  logic        mem_wmem,
   input  logic        mem_wreg,
   input  logic [4:0]  mem_rn,
   input  logic [1:0]  mem_size,
   input  logic        mem_sext,
   mem_lsu_if.master   dm,
   output logic [31:0] out_Alu_Result,
   output logic [31:0] out_mo,
   output logic        out_m2reg,
   output logic        out_wreg,
   output logic [4:0]  out_rn,
   output logic        mem_stall,
   output logic        mem_exc
);

   state_t        state;
   logic          req_q, we_q, err_q;
   logic [31:0]   addr_q, wdata_q, mo_q;
   logic [3:0]    be_q;
   logic [CW-1:0] cnt;

   logic          acc, mis, in_done, timeout_err;
   logic [3:0]    be_c;
   logic [31:0]   wrep_c, rext_c;

   lsu_align u_align (
      .size  (mem_size),
      .ofs   (mem_Alu_Result[1:0]),
      .sext  (mem_sext),
      .wdata (mem_wdata),
      .rdata (dm.rdata),
      .be    (be_c),
      .wrep  (wrep_c),
      .rext  (rext_c)
   );

   assign acc         = mem_valid & (mem_m2reg | mem_wmem);
   assign mis         = acc & is_misaligned(mem_size, mem_Alu_Result[1:0]);
   assign in_done     = (state == ST_DONE);
   assign timeout_err = in_done & err_q;

   // The instruction stays in EX/MEM until the DONE cycle, where it is released.
   assign mem_stall = ~rst & acc & ~mis & ~in_done;
   assign out_wreg  = ~rst & mem_valid & mem_wreg & ~mem_stall & ~mis & ~timeout_err;
   assign mem_exc   = ~rst & (mis | timeout_err);

   assign out_Alu_Result = mem_Alu_Result;
   assign out_m2reg      = mem_m2reg;
   assign out_rn         = mem_rn;
   assign out_mo         = in_done ? mo_q : 32'd0;

   assign dm.req   = req_q;
   assign dm.we    = we_q;
   assign dm.addr  = addr_q;
   assign dm.wdata = wdata_q;
   assign dm.be    = be_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         be_q    <= 4'd0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         mo_q    <= 32'd0;
         err_q   <= 1'b0;
         cnt     <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (acc && !mis) begin
                  state   <= ST_REQ;
                  req_q   <= 1'b1;
                  we_q    <= mem_wmem;
                  be_q    <= be_c;
                  addr_q  <= {mem_Alu_Result[31:2], 2'b00};
                  wdata_q <= wrep_c;
                  err_q   <= 1'b0;
                  cnt     <= '0;
               end
            end
            ST_REQ: begin
               // Load data is extracted from the instruction still held in EX/MEM.
               if (dm.ack) begin
                  mo_q  <= rext_c;
                  req_q <= 1'b0;
                  state <= ST_DONE;
               end else if (cnt == CW'(TIMEOUT - 1)) begin
                  req_q <= 1'b0;
                  err_q <= 1'b1;
                  state <= ST_DONE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_lsu.sv
// Testbench for mem_lsu: table of directed vectors with literal expectations,
// randomized vectors with expectations from a behavioural model, and
// hand-written reset sequences.
module tb_mem_lsu;

   localparam int TIMEOUT = 16;
   localparam int CW      = 5;

   logic        clk;
   logic        rst;
   logic        mem_valid;
   logic [31:0] mem_Alu_Result;
   logic [31:0] mem_wdata;
   logic        mem_m2reg;
   logic        mem_wmem;
   logic        mem_wreg;
   logic [4:0]  mem_rn;
   logic [1:0]  mem_size;
   logic        mem_sext;
   logic [31:0] out_Alu_Result;
   logic [31:0] out_mo;
   logic        out_m2reg;
   logic        out_wreg;
   logic [4:0]  out_rn;
   logic        mem_stall;
   logic        mem_exc;

   mem_lsu_if dm ();

   mem_lsu #(.TIMEOUT(TIMEOUT), .CW(CW)) dut (
      .clk            (clk),
      .rst            (rst),
      .mem_valid      (mem_valid),
      .mem_Alu_Result (mem_Alu_Result),
      .mem_wdata      (mem_wdata),
      .mem_m2reg      (mem_m2reg),
      .mem_wmem       (mem_wmem),
      .mem_wreg       (mem_wreg),
      .mem_rn         (mem_rn),
      .mem_size       (mem_size),
      .mem_sext       (mem_sext),
      .dm             (dm),
      .out_Alu_Result (out_Alu_Result),
      .out_mo         (out_mo),
      .out_m2reg      (out_m2reg),
      .out_wreg       (out_wreg),
      .out_rn         (out_rn),
      .mem_stall      (mem_stall),
      .mem_exc        (mem_exc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        vld, ld, st, wr;
      logic [4:0]  rn;
      logic [1:0]  size;
      logic        sext;
      logic [31:0] addr, wdata, rdata;
      int          dly;       // REQ cycles before the ack pulse
      logic [3:0]  e_be;
      logic [31:0] e_wdata, e_mo;
      int          e_stall;   // cycles with mem_stall high
      int          e_req;     // cycles with dm.req high
      logic        e_exc, e_wreg;
   } vec_t;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic vld, ld, st, wr, input logic [4:0] rn,
                               input logic [1:0] size, input logic sext,
                               input logic [31:0] addr, wdata, rdata, input int dly,
                               input logic [3:0] e_be, input logic [31:0] e_wdata, e_mo,
                               input int e_stall, e_req, input logic e_exc, e_wreg);
      vec_t v;
      v.vld = vld; v.ld = ld; v.st = st; v.wr = wr; v.rn = rn; v.size = size;
      v.sext = sext; v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.dly = dly;
      v.e_be = e_be; v.e_wdata = e_wdata; v.e_mo = e_mo; v.e_stall = e_stall;
      v.e_req = e_req; v.e_exc = e_exc; v.e_wreg = e_wreg;
      return v;
   endfunction

   // Behavioural reference: derives everything from the access rules with arithmetic.
   function automatic vec_t model(input vec_t v);
      vec_t        e;
      int          nb, ofs;
      logic [63:0] mask, piece, rep;
      logic        acc, mis;
      e    = v;
      ofs  = int'(v.addr % 4);
      nb   = (v.size == 2'd3) ? 4 : (1 << v.size);
      mask = (64'd1 << (8 * nb)) - 64'd1;
      e.e_be = 4'((((1 << nb) - 1) << ofs) & 15);
      piece = {32'd0, v.wdata} & mask;
      rep   = 64'd0;
      for (int k = 0; k < 4 / nb; k++) rep = rep | (piece << (8 * nb * k));
      e.e_wdata = rep[31:0];
      piece = ({32'd0, v.rdata} >> (8 * ofs)) & mask;
      if (v.sext && piece[8 * nb - 1]) piece = piece - (mask + 64'd1);
      e.e_mo = piece[31:0];
      acc = v.vld && (v.ld || v.st);
      mis = (v.size == 2'd3) || (v.addr % (nb) != 0);
      if (!acc) begin
         e.e_stall = 0; e.e_req = 0; e.e_exc = 1'b0; e.e_wreg = v.vld & v.wr;
      end else if (mis) begin
         e.e_stall = 0; e.e_req = 0; e.e_exc = 1'b1; e.e_wreg = 1'b0;
      end else if (v.dly >= TIMEOUT) begin
         e.e_stall = TIMEOUT + 1; e.e_req = TIMEOUT; e.e_exc = 1'b1; e.e_wreg = 1'b0;
      end else begin
         e.e_stall = v.dly + 2; e.e_req = v.dly + 1; e.e_exc = 1'b0; e.e_wreg = v.wr;
      end
      return e;
   endfunction

   // Entered and left just after a rising edge with the LSU idle.
   task automatic run_vec(input vec_t v, input string tag);
      int          nstall = 0, nreq = 0, seen = 0, cyc = 0;
      logic        done = 1'b0, stable = 1'b1, got = 1'b0;
      logic [31:0] s_addr, s_wdata;
      logic [3:0]  s_be;
      logic        s_we;
      s_addr = 32'd0; s_wdata = 32'd0; s_be = 4'd0; s_we = 1'b0;
      mem_valid = v.vld; mem_m2reg = v.ld; mem_wmem = v.st; mem_wreg = v.wr;
      mem_rn = v.rn; mem_Alu_Result = v.addr; mem_wdata = v.wdata;
      mem_size = v.size; mem_sext = v.sext;
      while (!done && cyc < TIMEOUT + 10) begin
         dm.ack = 1'b0;
         dm.rdata = $urandom;
         if (dm.req) begin
            seen++;
            if (seen - 1 == v.dly) begin
               dm.ack = 1'b1;
               dm.rdata = v.rdata;
            end
         end
         @(negedge clk);
         if (cyc == 0) begin
            chk({tag, ".out_rn"}, 32'(out_rn), 32'(v.rn));
            chk({tag, ".out_alu"}, out_Alu_Result, v.addr);
            chk({tag, ".out_m2reg"}, 32'(out_m2reg), 32'(v.ld));
         end
         if (dm.req) begin
            nreq++;
            if (!got) begin
               got = 1'b1; s_addr = dm.addr; s_wdata = dm.wdata; s_be = dm.be; s_we = dm.we;
            end else if (dm.addr !== s_addr || dm.wdata !== s_wdata || dm.be !== s_be || dm.we !== s_we) begin
               stable = 1'b0;
            end
         end
         if (mem_stall) begin
            nstall++;
            if (mem_exc || out_wreg) chk({tag, ".early_exc_wreg"}, {mem_exc, out_wreg}, 2'b00);
         end else begin
            done = 1'b1;
            chk({tag, ".stall_cycles"}, 32'(nstall), 32'(v.e_stall));
            chk({tag, ".req_cycles"}, 32'(nreq), 32'(v.e_req));
            chk({tag, ".exc"}, 32'(mem_exc), 32'(v.e_exc));
            chk({tag, ".out_wreg"}, 32'(out_wreg), 32'(v.e_wreg));
            chk({tag, ".req_final"}, 32'(dm.req), 32'd0);
            if (v.e_req > 0) begin
               chk({tag, ".be"}, 32'(s_be), 32'(v.e_be));
               chk({tag, ".addr"}, s_addr, {v.addr[31:2], 2'b00});
               chk({tag, ".we"}, 32'(s_we), 32'(v.st));
               chk({tag, ".bus_stable"}, 32'(stable), 32'd1);
               if (v.st) chk({tag, ".wdata"}, s_wdata, v.e_wdata);
               if (v.ld && v.dly < TIMEOUT) chk({tag, ".out_mo"}, out_mo, v.e_mo);
            end else begin
               chk({tag, ".out_mo_idle"}, out_mo, 32'd0);
            end
         end
         @(posedge clk); #1;
         cyc++;
      end
      if (!done) chk({tag, ".completion_bound"}, 32'(cyc), 32'(v.e_stall));
      dm.ack = 1'b0;
      mem_valid = 1'b0; mem_m2reg = 1'b0; mem_wmem = 1'b0; mem_wreg = 1'b0;
   endtask

   vec_t tbl[$];

   initial begin
      rst = 1'b1; dm.ack = 1'b0; dm.rdata = 32'd0;
      mem_valid = 1'b1; mem_m2reg = 1'b1; mem_wmem = 1'b0; mem_wreg = 1'b1;
      mem_rn = 5'd3; mem_Alu_Result = 32'h100; mem_wdata = 32'h0;
      mem_size = 2'd2; mem_sext = 1'b0;

      // Reset state with a live load presented.
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst.stall", 32'(mem_stall), 32'd0);
      chk("rst.out_wreg", 32'(out_wreg), 32'd0);
      chk("rst.req", 32'(dm.req), 32'd0);
      chk("rst.bus", {dm.addr ^ dm.wdata, 3'b000, dm.we, dm.be}, 40'd0);
      chk("rst.out_mo", out_mo, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0; mem_valid = 1'b0; mem_m2reg = 1'b0; mem_wreg = 1'b0;

      //          vld ld st wr rn    sz    sx  addr          wdata         rdata         dly  be       wdata         mo            stl        req      exc  wreg
      tbl.push_back(mk(1, 0, 0, 1, 5'd7, 2'd2, 0, 32'h0000_1234, 32'h0,       32'h0,        0,   4'h0,    32'h0,        32'h0,        0,         0,       0,   1));
      tbl.push_back(mk(1, 1, 0, 1, 5'd9, 2'd2, 0, 32'h0000_0100, 32'h0,       32'hDEADBEEF, 1,   4'b1111, 32'h0,        32'hDEADBEEF, 3,         2,       0,   1));
      tbl.push_back(mk(1, 1, 0, 1, 5'd4, 2'd0, 1, 32'h0000_0103, 32'h0,       32'h80FFFFFF, 0,   4'b1000, 32'h0,        32'hFFFFFF80, 2,         1,       0,   1));
      tbl.push_back(mk(1, 1, 0, 1, 5'd4, 2'd0, 0, 32'h0000_0103, 32'h0,       32'h80FFFFFF, 0,   4'b1000, 32'h0,        32'h00000080, 2,         1,       0,   1));
      tbl.push_back(mk(1, 0, 1, 0, 5'd0, 2'd1, 0, 32'h0000_0202, 32'h0000ABCD, 32'h0,       1,   4'b1100, 32'hABCDABCD, 32'h0,        3,         2,       0,   0));
      tbl.push_back(mk(1, 1, 0, 1, 5'd2, 2'd2, 0, 32'h0000_0101, 32'h0,       32'h0,        0,   4'h0,    32'h0,        32'h0,        0,         0,       1,   0));
      tbl.push_back(mk(1, 1, 0, 1, 5'd2, 2'd2, 0, 32'h0000_0300, 32'h0,       32'h0,        99,  4'b1111, 32'h0,        32'h0,        TIMEOUT+1, TIMEOUT, 1,   0));
      tbl.push_back(mk(1, 1, 0, 1, 5'd6, 2'd1, 1, 32'h0000_0102, 32'h0,       32'h80010000, 2,   4'b1100, 32'h0,        32'hFFFF8001, 4,         3,       0,   1));
      tbl.push_back(mk(1, 0, 1, 0, 5'd0, 2'd0, 0, 32'h0000_0101, 32'h12345678, 32'h0,       0,   4'b0010, 32'h78787878, 32'h0,        2,         1,       0,   0));
      tbl.push_back(mk(1, 1, 0, 1, 5'd1, 2'd3, 0, 32'h0000_0100, 32'h0,       32'h0,        0,   4'h0,    32'h0,        32'h0,        0,         0,       1,   0));
      tbl.push_back(mk(1, 1, 0, 1, 5'd1, 2'd1, 0, 32'h0000_0103, 32'h0,       32'h0,        0,   4'h0,    32'h0,        32'h0,        0,         0,       1,   0));
      tbl.push_back(mk(1, 0, 1, 0, 5'd0, 2'd2, 0, 32'h0000_0400, 32'hCAFEF00D, 32'h0,       TIMEOUT-1, 4'b1111, 32'hCAFEF00D, 32'h0, TIMEOUT+1, TIMEOUT, 0, 0));

      foreach (tbl[i]) run_vec(tbl[i], $sformatf("tbl%0d", i));

      // Reset during REQ; a late ack must be ignored.
      mem_valid = 1'b1; mem_m2reg = 1'b1; mem_wreg = 1'b1; mem_size = 2'd2;
      mem_Alu_Result = 32'h100; mem_rn = 5'd8;
      @(posedge clk); #1;
      @(negedge clk);
      chk("midrst.req_before", 32'(dm.req), 32'd1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      chk("midrst.stall_in_rst", 32'(mem_stall), 32'd0);
      chk("midrst.wreg_in_rst", 32'(out_wreg), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0; mem_valid = 1'b0; mem_m2reg = 1'b0; mem_wreg = 1'b0;
      @(negedge clk);
      chk("midrst.req_after", 32'(dm.req), 32'd0);
      chk("midrst.be_after", 32'(dm.be), 32'd0);
      @(posedge clk); #1;
      dm.ack = 1'b1; dm.rdata = 32'h1234_5678;
      @(negedge clk);
      chk("midrst.exc_on_ack", 32'(mem_exc), 32'd0);
      chk("midrst.mo_on_ack", out_mo, 32'd0);
      @(posedge clk); #1;
      dm.ack = 1'b0;
      @(negedge clk);
      chk("midrst.exc_after_ack", 32'(mem_exc), 32'd0);
      chk("midrst.mo_after_ack", out_mo, 32'd0);
      chk("midrst.req_after_ack", 32'(dm.req), 32'd0);
      @(posedge clk); #1;
      run_vec(tbl[1], "midrst.recover");

      // Randomized accesses against the reference model.
      for (int i = 0; i < 60; i++) begin
         vec_t v;
         int   k, r;
         v = tbl[0];
         v.vld = ($urandom_range(0, 9) != 0);
         k = $urandom_range(0, 2);
         v.ld = (k == 0); v.st = (k == 1);
         v.wr = v.ld ? 1'b1 : (v.st ? 1'b0 : 1'($urandom_range(0, 1)));
         v.rn = 5'($urandom);
         r = $urandom_range(0, 9);
         v.size = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
         v.sext = 1'($urandom_range(0, 1));
         v.addr = $urandom;
         if ($urandom_range(0, 3) != 0 && v.size != 2'd3)
            v.addr = v.addr & ~((32'd1 << v.size) - 32'd1);
         v.wdata = $urandom;
         v.rdata = $urandom;
         v.dly = ($urandom_range(0, 7) == 0) ? 30 : $urandom_range(0, 4);
         run_vec(model(v), $sformatf("rnd%0d", i));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_chk, n_fail);
      $fatal(1, "watchdog");
   end

endmodule
